// File: rtl/pc_fetch_unit.sv
// Program-counter stage: boots for a fixed number of cycles, then selects and registers
// the next PC (jump > branch > sequential), retires instructions and stops on halt.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCSel,
    input  logic [31:0] SignImm,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic        Stall,
    input  logic        HaltReq,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Halted,
    output logic [31:0] InstrCount,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT   = {RESET_PC[31:2], 2'b00};
    localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] count_q, count_d;
    logic [3:0]  boot_q, boot_d;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] count_inc;

    assign PCPlus4       = pc_q + 32'd4;
    assign branch_target = PCPlus4 + (SignImm << 2);
    assign jump_target   = {PCPlus4[31:28], JumpTarget, 2'b00};
    // Retired count saturates instead of wrapping.
    assign count_inc     = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    // FetchValid qualifies PC: high only in RUN, where the PC is a real fetch address.
    // There is no back-pressure path; Stall simply freezes the stage for a cycle.
    assign PC         = pc_q;
    assign FetchValid = (state_q == ST_RUN);
    assign Halted     = (state_q == ST_HALT);
    assign InstrCount = count_q;
    assign fsm_state  = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        boot_d  = boot_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    boot_d = boot_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (!Stall) begin
                    count_d = count_inc;
                    if (HaltReq) begin
                        // Halt retires in place: PC stays on the halt instruction.
                        state_d = ST_HALT;
                    end else if (Jump) begin
                        pc_d = jump_target;
                    end else if (PCSel) begin
                        pc_d = branch_target;
                    end else begin
                        pc_d = PCPlus4;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= PC_INIT;
            count_q <= 32'd0;
            boot_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            boot_q  <= boot_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: boot timing, directed next-PC vectors, stall/halt/reset
// sequences, wrap and saturation, then random stimulus against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0040_0000;
    localparam int          BOOT_CYCLES = 2;

    logic        clk;
    logic        rst_n;
    logic        pcsel;
    logic [31:0] sign_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] instr_count;
    logic [1:0]  fsm_state;

    // Second instance parked near the top of the address space, sequential only.
    logic        rst_w;
    logic        zero_bit;
    logic [31:0] zero_word;
    logic [25:0] zero_jt;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_fetch_valid;
    logic        w_halted;
    logic [31:0] w_count;
    logic [1:0]  w_state;

    int total;
    int passed;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_boot_left;
    logic        m_run;
    logic        m_halt;

    typedef struct packed {
        logic        pcsel;
        logic [31:0] imm;
        logic        jump;
        logic [25:0] jt;
        logic        stall;
        logic        halt;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];

    pc_fetch_unit #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .PCSel(pcsel), .SignImm(sign_imm), .Jump(jump),
        .JumpTarget(jump_target), .Stall(stall), .HaltReq(halt_req), .PC(pc),
        .PCPlus4(pc_plus4), .FetchValid(fetch_valid), .Halted(halted),
        .InstrCount(instr_count), .fsm_state(fsm_state)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFB), .BOOT_CYCLES(1)) dut_w (
        .clk(clk), .rst_n(rst_w), .PCSel(zero_bit), .SignImm(zero_word), .Jump(zero_bit),
        .JumpTarget(zero_jt), .Stall(zero_bit), .HaltReq(zero_bit), .PC(w_pc),
        .PCPlus4(w_pc_plus4), .FetchValid(w_fetch_valid), .Halted(w_halted),
        .InstrCount(w_count), .fsm_state(w_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Behavioural reference: boot countdown, then the next-PC rules applied with arithmetic.
    task automatic model_reset();
        m_pc        = {RESET_PC[31:2], 2'b00};
        m_cnt       = 32'd0;
        m_boot_left = BOOT_CYCLES;
        m_run       = 1'b0;
        m_halt      = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        if (!rst_n) begin
            model_reset();
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (!m_run) begin
            m_boot_left = m_boot_left - 1;
            if (m_boot_left == 0) m_run = 1'b1;
        end else if (!stall) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (halt_req) begin
                m_halt = 1'b1;
                m_run  = 1'b0;
            end else if (jump) begin
                m_pc = {seq[31:28], jump_target, 2'b00};
            end else if (pcsel) begin
                m_pc = seq + sign_imm * 32'd4;
            end else begin
                m_pc = seq;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, "_fv"}, {31'd0, fetch_valid}, {31'd0, m_run});
        check({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halt});
        check({tag, "_cnt"}, instr_count, m_cnt);
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic p, input logic [31:0] imm, input logic j,
                         input logic [25:0] jt, input logic s, input logic h);
        pcsel       = p;
        sign_imm    = imm;
        jump        = j;
        jump_target = jt;
        stall       = s;
        halt_req    = h;
    endtask

    task automatic drive_idle();
        drive(1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check({tag, "_pc_now"}, pc, RESET_PC);
        check({tag, "_fv_now"}, {31'd0, fetch_valid}, 32'd0);
        check({tag, "_cnt_now"}, instr_count, 32'd0);
        check({tag, "_halted_now"}, {31'd0, halted}, 32'd0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        zero_bit  = 1'b0;
        zero_word = 32'd0;
        zero_jt   = 26'd0;
        rst_n     = 1'b0;
        rst_w     = 1'b0;
        drive_idle();
        model_reset();

        vecs[0]  = '{1'b0, 32'h0,        1'b1, 26'h0000004, 1'b0, 1'b0, 32'h0000_0010, 32'd3};
        vecs[1]  = '{1'b1, 32'h3,        1'b0, 26'h0,       1'b0, 1'b0, 32'h0000_0020, 32'd4};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0,      1'b0, 1'b0, 32'h0000_001C, 32'd5};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 26'h0100004, 1'b0, 1'b0, 32'h0040_0010, 32'd6};
        vecs[4]  = '{1'b1, 32'h5,        1'b1, 26'h0100000, 1'b0, 1'b0, 32'h0040_0000, 32'd7};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 26'h0000010, 1'b0, 1'b0, 32'h0000_0040, 32'd8};
        vecs[6]  = '{1'b1, 32'h7,        1'b0, 26'h0,       1'b1, 1'b0, 32'h0000_0040, 32'd8};
        vecs[7]  = '{1'b1, 32'h7,        1'b0, 26'h0,       1'b1, 1'b0, 32'h0000_0040, 32'd8};
        vecs[8]  = '{1'b1, 32'h7,        1'b0, 26'h0,       1'b1, 1'b0, 32'h0000_0040, 32'd8};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 26'h0000123, 1'b1, 1'b1, 32'h0000_0040, 32'd8};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 1'b0, 32'h0000_0044, 32'd9};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0,      1'b0, 1'b0, 32'h0000_0044, 32'd10};
        vecs[12] = '{1'b0, 32'h0,        1'b1, 26'h0000020, 1'b0, 1'b0, 32'h0000_0080, 32'd11};

        // Reset values, then boot timing
        #12;
        check_model("reset");
        check("reset_pc_const", pc, 32'h0040_0000);
        check("w_reset_pc", w_pc, 32'hFFFF_FFF8);
        #1 rst_n = 1'b1;
        rst_w = 1'b1;
        step();
        check_model("boot1");
        check("boot1_fv", {31'd0, fetch_valid}, 32'd0);
        check("w_boot1_fv", {31'd0, w_fetch_valid}, 32'd1);
        check("w_boot1_pc", w_pc, 32'hFFFF_FFF8);
        step();
        check_model("boot2");
        check("boot2_fv", {31'd0, fetch_valid}, 32'd1);
        check("boot2_pc", pc, 32'h0040_0000);
        check("w_seq1_pc", w_pc, 32'hFFFF_FFFC);
        check("w_wrap_pc4", w_pc_plus4, 32'h0000_0000);
        step();
        check_model("run1");
        check("run1_pc", pc, 32'h0040_0004);
        check("w_wrap_pc", w_pc, 32'h0000_0000);
        step();
        check_model("run2");
        check("run2_pc", pc, 32'h0040_0008);

        // Directed next-PC / stall vectors
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].pcsel, vecs[i].imm, vecs[i].jump, vecs[i].jt, vecs[i].stall, vecs[i].halt);
            step();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_cnt", i), instr_count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_fv", i), {31'd0, fetch_valid}, 32'd1);
            check_model($sformatf("vec%0d_model", i));
        end

        // Halt beats jump, then everything is ignored
        drive(1'b1, 32'h9, 1'b1, 26'h0000005, 1'b0, 1'b1);
        step();
        check("halt_pc", pc, 32'h0000_0080);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_fv", {31'd0, fetch_valid}, 32'd0);
        check("halt_cnt", instr_count, 32'd12);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 26'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            check($sformatf("halted%0d_pc", i), pc, 32'h0000_0080);
            check($sformatf("halted%0d_cnt", i), instr_count, 32'd12);
            check($sformatf("halted%0d_flag", i), {31'd0, halted}, 32'd1);
        end

        // Asynchronous reset out of HALT and mid-run, boot repeats each time
        drive_idle();
        async_reset_check("rst_halt");
        step();
        step();
        drive(1'b0, 32'd0, 1'b1, 26'h000048D, 1'b0, 1'b0);
        step();
        check("jmp1234_pc", pc, 32'h0000_1234);
        drive_idle();
        async_reset_check("rst_run");
        step();
        check("reboot1_fv", {31'd0, fetch_valid}, 32'd0);
        step();
        check("reboot2_fv", {31'd0, fetch_valid}, 32'd1);
        check("reboot2_pc", pc, 32'h0040_0000);
        step();
        check("reboot3_pc", pc, 32'h0040_0004);
        check_model("reboot3");

        // Saturation from a preloaded count
        #1 force dut.count_q = 32'hFFFF_FFFE;
        #1 release dut.count_q;
        m_cnt = 32'hFFFF_FFFE;
        check("sat_preload", instr_count, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sat%0d_cnt", i), instr_count, 32'hFFFF_FFFF);
            check_model($sformatf("sat%0d", i));
        end

        // Random stimulus against the model
        drive_idle();
        async_reset_check("rnd_start");
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
                  26'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
            step();
            check_model($sformatf("rnd%0d", i));
            if ((m_halt && $urandom_range(0, 4) == 0) || $urandom_range(0, 99) == 0) begin
                async_reset_check($sformatf("rnd%0d_rst", i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
